// File: rtl/serial_load_ctrl_pkg.sv
// Shared definitions for the serial-in/parallel-out load controller:
// FSM state encoding and the width of the bit counter.
package serial_load_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

    // One extra bit so that the full frame length itself is representable.
    function automatic int count_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_load_ctrl_sipo_reg.sv
// WIDTH-bit shift register with enable, synchronous clear and a selectable
// shift direction; exposes the value it would hold after the current shift.
module sipo_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] word_next_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // MSB-first pushes toward bit WIDTH-1; LSB-first pushes toward bit 0.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign word_next_o = {sr_q[WIDTH-2:0], ser_i};
        end else begin : g_lsb_first
            assign word_next_o = {ser_i, sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        sr_d = sr_q;
        if (clr_i) begin
            sr_d = '0;
        end else if (en_i) begin
            sr_d = word_next_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/serial_load_ctrl.sv
// Frame sequencer: on Start, shifts exactly WIDTH serial bits in, publishes
// the word on Data and holds it under a Valid/Ack handshake.
module serial_load_ctrl
    import serial_load_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic                            Start,
    input  logic                            SerIn,
    input  logic                            Ack,
    output logic                            Busy,
    output logic                            Valid,
    output logic [WIDTH-1:0]                Data,
    output logic [count_width(WIDTH)-1:0]   Count
);

    localparam int            CW       = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic              sr_clr;
    logic              sr_en;
    logic [WIDTH-1:0]  sr_word_next;

    sipo_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sipo_reg (
        .clk_i       (Clock),
        .srst_i      (Reset),
        .clr_i       (sr_clr),
        .en_i        (sr_en),
        .ser_i       (SerIn),
        .word_next_o (sr_word_next)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        sr_clr  = 1'b0;
        sr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_SHIFT;
                    count_d = '0;
                    sr_clr  = 1'b1;
                end
            end
            ST_SHIFT: begin
                sr_en   = 1'b1;
                count_d = count_q + CW'(1);
                // The final bit goes straight into Data on the same edge.
                if (count_q == LAST_BIT) begin
                    state_d = ST_HOLD;
                    data_d  = sr_word_next;
                end
            end
            ST_HOLD: begin
                if (Ack) begin
                    count_d = '0;
                    if (Start) begin
                        state_d = ST_SHIFT;
                        sr_clr  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase

        busy_d  = (state_d == ST_SHIFT);
        valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign Busy  = busy_q;
    assign Valid = valid_q;
    assign Data  = data_q;
    assign Count = count_q;

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Scoreboard bench: two controllers (MSB-first and LSB-first) share one
// stimulus stream; completed words and latency are checked by a monitor.
module tb_serial_load_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          SerIn = 1'b0;
    logic          Ack   = 1'b0;
    logic          busy_a, valid_a, busy_b, valid_b;
    logic [W-1:0]  data_a, data_b;
    logic [CW-1:0] count_a, count_b;

    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .Clock (Clock), .Reset (Reset), .Start (Start), .SerIn (SerIn), .Ack (Ack),
        .Busy  (busy_a), .Valid (valid_a), .Data (data_a), .Count (count_a)
    );

    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .Clock (Clock), .Reset (Reset), .Start (Start), .SerIn (SerIn), .Ack (Ack),
        .Busy  (busy_b), .Valid (valid_b), .Data (data_b), .Count (count_b)
    );

    typedef struct {
        logic [W-1:0] wa;
        logic [W-1:0] wb;
        int           due;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    int           n_frames = 0;
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;
    logic         prev_valid = 1'b0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Word as seen when the first bit in time is the least significant one.
    function automatic logic [W-1:0] rev(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
        return r;
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Monitor: a rising Valid means a frame completed; compare against the oldest expectation.
    always @(negedge Clock) begin
        if (valid_a && !prev_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got valid=1, expected no pending frame (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_msb_first", data_a, e.wa);
                chk("data_lsb_first", data_b, e.wb);
                chk("start_to_valid_cycle", cyc, e.due);
                chk("valid_lsb_dut", valid_b, 1);
                n_frames++;
                $display("frame %0d: msb_first=%h lsb_first=%h at cycle %0d", n_frames, data_a, data_b, cyc);
            end
        end
        prev_valid = valid_a;
    end

    // Issues Start (with Ack, so it also works from HOLD) then streams the bits of
    // w, first bit = w[W-1]. abort_at >= 0 applies Reset after that many bits.
    task automatic run_frame(input logic [W-1:0] w, input bit hold_start, input int abort_at,
                             output bit aborted);
        int n0;
        aborted = 1'b0;
        Start = 1'b1;
        Ack   = 1'b1;
        SerIn = 1'($urandom);
        step();
        n0 = cyc;
        sb.push_back('{wa: w, wb: rev(w), due: n0 + W});
        chk("busy_after_start", busy_a, 1);
        chk("count_after_start", count_a, 0);
        chk("valid_after_start", valid_a, 0);
        for (int i = 0; i < W; i++) begin
            if (abort_at == i) begin
                Start = 1'b1;
                Ack   = 1'b1;
                Reset = 1'b1;
                step();
                Reset = 1'b0;
                Start = 1'b0;
                Ack   = 1'b0;
                sb.delete();
                last_a = '0;
                last_b = '0;
                chk("abort_busy", busy_a, 0);
                chk("abort_count", count_a, 0);
                chk("abort_data_msb", data_a, 0);
                chk("abort_data_lsb", data_b, 0);
                chk("abort_valid", valid_a, 0);
                aborted = 1'b1;
                return;
            end
            Start = hold_start ? 1'b1 : 1'($urandom);
            Ack   = 1'($urandom);
            SerIn = w[W-1-i];
            step();
            chk("count_bits", count_a, i + 1);
            if (i < W - 1) begin
                chk("busy_in_shift", busy_a, 1);
                chk("valid_in_shift", valid_a, 0);
                chk("data_kept_msb", data_a, last_a);
                chk("data_kept_lsb", data_b, last_b);
            end
        end
        chk("valid_at_end", valid_a, 1);
        chk("busy_at_end", busy_a, 0);
        last_a = w;
        last_b = rev(w);
        Start = 1'b0;
        Ack   = 1'b0;
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            Start = 1'($urandom);
            Ack   = 1'b0;
            step();
            chk("hold_valid", valid_a, 1);
            chk("hold_busy", busy_a, 0);
            chk("hold_count", count_a, W);
            chk("hold_data", data_a, last_a);
        end
        Start = 1'b0;
    endtask

    task automatic release_to_idle();
        Ack   = 1'b1;
        Start = 1'b0;
        step();
        chk("ack_valid", valid_a, 0);
        chk("ack_busy", busy_a, 0);
        chk("ack_count", count_a, 0);
        Ack = 1'b0;
        step();
        chk("idle_data_msb", data_a, last_a);
        chk("idle_data_lsb", data_b, last_b);
        chk("idle_busy", busy_a, 0);
    endtask

    initial begin
        bit ab;
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        chk("reset_busy", busy_a, 0);
        chk("reset_valid", valid_a, 0);
        chk("reset_data", data_a, 0);
        chk("reset_count", count_a, 0);
        chk("reset_data_lsb", data_b, 0);

        run_frame(8'hA5, 1'b0, -1, ab);
        hold(5);
        release_to_idle();

        run_frame(8'hC0, 1'b0, -1, ab);
        release_to_idle();

        run_frame(8'hA5, 1'b0, -1, ab);
        run_frame(8'h3C, 1'b0, -1, ab);
        release_to_idle();

        run_frame(8'h96, 1'b0, 4, ab);
        run_frame(8'h5A, 1'b1, -1, ab);
        hold(2);
        release_to_idle();

        for (int k = 0; k < 20; k++) begin
            int abort_at;
            abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            run_frame(W'($urandom), 1'($urandom), abort_at, ab);
            if (!ab) begin
                hold(int'($urandom_range(0, 3)));
                if ($urandom_range(0, 1) == 1) release_to_idle();
            end
        end

        step();
        step();
        chk("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
